// File: rtl/tpu_pkg.sv
// Shared TPU types: instruction word, dispatcher opcode classes and FSM states.
package tpu_pkg;

    localparam int OPCODE_WIDTH  = 8;
    localparam int OPERAND_WIDTH = 24;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [OPERAND_WIDTH-1:0] operand;
    } instr_type;

    localparam instr_type INIT_INSTR = '{opcode: 8'h00, operand: 24'h000000};

    localparam logic [4:0] CLASS_NOP    = 5'b00000;
    localparam logic [4:0] CLASS_WEIGHT = 5'b00001;
    localparam logic [4:0] CLASS_MMU    = 5'b00010;
    localparam logic [4:0] CLASS_ACT    = 5'b00100;
    localparam logic [4:0] CLASS_HALT   = 5'b11111;

    typedef enum logic [1:0] {
        DISP_RUN    = 2'd0,
        DISP_DRAIN  = 2'd1,
        DISP_HALTED = 2'd2
    } disp_state_type;

    function automatic logic [4:0] opcode_class(input logic [OPCODE_WIDTH-1:0] opcode);
        return opcode[OPCODE_WIDTH-1:3];
    endfunction

    function automatic logic class_is_legal(input logic [4:0] cls);
        return (cls == CLASS_NOP)  || (cls == CLASS_WEIGHT) || (cls == CLASS_MMU) ||
               (cls == CLASS_ACT)  || (cls == CLASS_HALT);
    endfunction

endpackage

// File: rtl/instruction_dispatcher.sv
// Issues buffered instructions to weight loader / MMU / activation unit through a
// one-deep hold stage, with HALT drain/synchronize handling and performance counters.
module instruction_dispatcher
    import tpu_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  instr_type                instr_in,
    input  logic                     instr_valid,
    output logic                     lab_busy,
    output instr_type                weight_instr,
    output logic                     weight_en,
    input  logic                     weight_busy,
    output instr_type                mmu_instr,
    output logic                     mmu_en,
    input  logic                     mmu_busy,
    output instr_type                act_instr,
    output logic                     act_en,
    input  logic                     act_busy,
    input  logic                     resume,
    output logic                     synchronize,
    output logic                     halted,
    output logic                     illegal_opcode,
    output logic [COUNTER_WIDTH-1:0] issue_count,
    output logic [COUNTER_WIDTH-1:0] stall_count
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    disp_state_type state_r;
    disp_state_type state_nxt_s;
    instr_type      hold_reg;
    logic           hold_valid;
    logic           pend_w;
    logic           pend_m;
    logic           pend_a;
    logic [4:0]     hold_class_s;
    logic           free_w_s;
    logic           free_m_s;
    logic           free_a_s;
    logic           can_issue_s;
    logic           consume_s;
    logic           stall_s;
    logic           accept_s;
    logic           issue_s;
    logic           drain_done_s;

    assign hold_class_s = opcode_class(hold_reg.opcode);
    assign free_w_s     = !weight_busy && !pend_w;
    assign free_m_s     = !mmu_busy && !pend_m;
    // ACT reads the accumulators the MMU writes, so it also waits for a free MMU
    assign free_a_s     = !act_busy && !pend_a && free_m_s;
    assign drain_done_s = !weight_busy && !mmu_busy && !act_busy && !pend_w && !pend_m && !pend_a;
    assign accept_s     = instr_valid && !lab_busy;
    assign issue_s      = weight_en || mmu_en || act_en;
    assign halted       = (state_r == DISP_HALTED);

    // Issue readiness of the held instruction; depends only on registered state and busy inputs
    always_comb begin
        can_issue_s = 1'b0;
        case (hold_class_s)
            CLASS_WEIGHT: can_issue_s = free_w_s;
            CLASS_MMU:    can_issue_s = free_m_s;
            CLASS_ACT:    can_issue_s = free_a_s;
            CLASS_HALT:   can_issue_s = hold_valid;
            default:      can_issue_s = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DISP_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DISP_RUN: begin
                if (consume_s && (hold_class_s == CLASS_HALT)) begin
                    state_nxt_s = DISP_DRAIN;
                end else begin
                    state_nxt_s = DISP_RUN;
                end
            end
            DISP_DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = DISP_HALTED;
                end else begin
                    state_nxt_s = DISP_DRAIN;
                end
            end
            DISP_HALTED: begin
                if (resume) begin
                    state_nxt_s = DISP_RUN;
                end else begin
                    state_nxt_s = DISP_HALTED;
                end
            end
            default: state_nxt_s = DISP_RUN;
        endcase
    end

    // FSM outputs: back-pressure, issue strobes and the instruction buses
    always_comb begin
        lab_busy     = 1'b0;
        consume_s    = 1'b0;
        stall_s      = 1'b0;
        weight_en    = 1'b0;
        mmu_en       = 1'b0;
        act_en       = 1'b0;
        weight_instr = INIT_INSTR;
        mmu_instr    = INIT_INSTR;
        act_instr    = INIT_INSTR;
        case (state_r)
            DISP_RUN: begin
                lab_busy = hold_valid && !can_issue_s;
                stall_s  = hold_valid && !can_issue_s;
                if (hold_valid && can_issue_s) begin
                    consume_s = 1'b1;
                    case (hold_class_s)
                        CLASS_WEIGHT: begin
                            weight_en    = 1'b1;
                            weight_instr = hold_reg;
                        end
                        CLASS_MMU: begin
                            mmu_en    = 1'b1;
                            mmu_instr = hold_reg;
                        end
                        CLASS_ACT: begin
                            act_en    = 1'b1;
                            act_instr = hold_reg;
                        end
                        default: consume_s = 1'b1;
                    endcase
                end else begin
                    consume_s = 1'b0;
                end
            end
            DISP_DRAIN: begin
                lab_busy = 1'b1;
                stall_s  = 1'b1;
            end
            DISP_HALTED: lab_busy = 1'b1;
            default:     lab_busy = 1'b0;
        endcase
    end

    // Skid/hold stage: accept and issue may happen in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg   <= INIT_INSTR;
            hold_valid <= 1'b0;
        end else if (accept_s) begin
            hold_reg   <= instr_in;
            hold_valid <= 1'b1;
        end else if (consume_s) begin
            hold_valid <= 1'b0;
        end
    end

    // Pending guards cover the cycle before a freshly issued unit raises busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w <= 1'b0;
            pend_m <= 1'b0;
            pend_a <= 1'b0;
        end else begin
            pend_w <= weight_en;
            pend_m <= mmu_en;
            pend_a <= act_en;
        end
    end

    // Sticky illegal flag and synchronize pulse on HALTED entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_opcode <= 1'b0;
            synchronize    <= 1'b0;
        end else begin
            if (consume_s && !class_is_legal(hold_class_s)) begin
                illegal_opcode <= 1'b1;
            end
            synchronize <= (state_r == DISP_DRAIN) && drain_done_s;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue_s && !(&issue_count)) begin
                issue_count <= issue_count + CNT_ONE;
            end
            if (stall_s && !(&stall_count)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher: per-cycle comparison against a
// timestamp/queue-level model plus hand-computed literal expectations.
module tb_instruction_dispatcher;
    import tpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    instr_type   instr_in = INIT_INSTR;
    logic        instr_valid = 1'b0;
    logic        lab_busy;
    instr_type   weight_instr, mmu_instr, act_instr;
    logic        weight_en, mmu_en, act_en;
    logic        weight_busy = 1'b0, mmu_busy = 1'b0, act_busy = 1'b0;
    logic        resume = 1'b0;
    logic        synchronize, halted, illegal_opcode;
    logic [31:0] issue_count, stall_count;

    int checks = 0;
    int passes = 0;

    instruction_dispatcher #(.COUNTER_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .lab_busy(lab_busy),
        .weight_instr(weight_instr), .weight_en(weight_en), .weight_busy(weight_busy),
        .mmu_instr(mmu_instr), .mmu_en(mmu_en), .mmu_busy(mmu_busy),
        .act_instr(act_instr), .act_en(act_en), .act_busy(act_busy),
        .resume(resume), .synchronize(synchronize), .halted(halted),
        .illegal_opcode(illegal_opcode), .issue_count(issue_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MODE_RUN = 0, MODE_DRAIN = 1, MODE_HALTED = 2;
    int        cyc, last_w, last_m, last_a, mode, cls;
    bit        m_hv, m_sync, m_ill, issued;
    instr_type m_held;
    longint    m_issue, m_stall;
    bit        fw, fm, fa, e_ok, e_busy, e_we, e_me, e_ae;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; last_w = -10; last_m = -10; last_a = -10;
            mode = MODE_RUN; m_hv = 0; m_held = INIT_INSTR;
            m_sync = 0; m_ill = 0; m_issue = 0; m_stall = 0;
        end
        cls  = m_hv ? int'(m_held.opcode >> 3) : -1;
        fw   = !weight_busy && (cyc != last_w + 1);
        fm   = !mmu_busy && (cyc != last_m + 1);
        fa   = !act_busy && (cyc != last_a + 1) && fm;
        e_ok = (cls == 1) ? fw : (cls == 2) ? fm : (cls == 4) ? fa : 1'b1;
        issued = (mode == MODE_RUN) && m_hv && e_ok;
        e_busy = (mode != MODE_RUN) || (m_hv && !e_ok);
        e_we = issued && (cls == 1);
        e_me = issued && (cls == 2);
        e_ae = issued && (cls == 4);

        check("lab_busy", lab_busy, e_busy);
        check("weight_en", weight_en, e_we);
        check("mmu_en", mmu_en, e_me);
        check("act_en", act_en, e_ae);
        check("weight_instr", weight_instr, e_we ? m_held : INIT_INSTR);
        check("mmu_instr", mmu_instr, e_me ? m_held : INIT_INSTR);
        check("act_instr", act_instr, e_ae ? m_held : INIT_INSTR);
        check("synchronize", synchronize, m_sync);
        check("halted", halted, mode == MODE_HALTED);
        check("illegal_opcode", illegal_opcode, m_ill);
        check("issue_count", issue_count, m_issue);
        check("stall_count", stall_count, m_stall);

        if (!rst) begin
            m_sync = 0;
            if (mode == MODE_RUN) begin
                if (issued) begin
                    if (e_we) last_w = cyc;
                    if (e_me) last_m = cyc;
                    if (e_ae) last_a = cyc;
                    if (e_we || e_me || e_ae) m_issue++;
                    if (!(cls inside {0, 1, 2, 4, 31})) m_ill = 1;
                    if (cls == 31) mode = MODE_DRAIN;
                end else if (m_hv) begin
                    m_stall++;
                end
                if (instr_valid && !e_busy) begin
                    m_held = instr_in;
                    m_hv   = 1;
                end else if (issued) begin
                    m_hv = 0;
                end
            end else if (mode == MODE_DRAIN) begin
                m_stall++;
                if (!weight_busy && !mmu_busy && !act_busy && cyc != last_w + 1 &&
                    cyc != last_m + 1 && cyc != last_a + 1) begin
                    mode   = MODE_HALTED;
                    m_sync = 1;
                end
            end else if (resume) begin
                mode = MODE_RUN;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [23:0] operand);
        instr_valid     = v;
        instr_in.opcode = op;
        instr_in.operand = operand;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        drive(1'b0, 8'h00, 24'h0);
        weight_busy = 1'b0; mmu_busy = 1'b0; act_busy = 1'b0; resume = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        #2;
        check("rst_lab_busy", lab_busy, 1'b0);
        check("rst_issue_count", issue_count, 32'd0);
        tick();
        rst = 1'b0;

        // Illegal class 5'b01000 followed by a NOP
        drive(1'b1, 8'h40, 24'h111111);
        tick(); drive(1'b1, 8'h05, 24'h222222);
        #2; check("ill_no_en", {weight_en, mmu_en, act_en}, 3'b000);
        tick(); drive(1'b0, 8'h00, 24'h0);
        #2; check("ill_flag", illegal_opcode, 1'b1);
        tick();
        #2; check("ill_sticky", illegal_opcode, 1'b1);
        check("ill_issue_count", issue_count, 32'd0);

        // WEIGHT, MMU, ACT back to back with idle units
        do_reset();
        drive(1'b1, 8'h08, 24'hABCDEF);
        tick(); drive(1'b1, 8'h10, 24'h000123);
        #2; check("t1_weight_en_c1", weight_en, 1'b1);
        check("t1_weight_instr", weight_instr, 32'h08ABCDEF);
        tick(); drive(1'b1, 8'h20, 24'h000456);
        #2; check("t1_mmu_en_c2", mmu_en, 1'b1);
        tick(); drive(1'b0, 8'h00, 24'h0);
        #2; check("t1_act_stall_c3", {act_en, lab_busy}, 2'b01);
        tick();
        #2; check("t1_act_en_c4", act_en, 1'b1);
        tick(); tick();
        #2; check("t1_issue_count", issue_count, 32'd3);
        check("t1_stall_count", stall_count, 32'd1);

        // MMU held behind 5 busy cycles
        drive(1'b1, 8'h10, 24'h00AAAA); mmu_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1'b0, 8'h00, 24'h0);
            #2; check("t2_busy_hold", {lab_busy, mmu_en}, 2'b10);
        end
        tick(); mmu_busy = 1'b0;
        #2; check("t2_mmu_en", mmu_en, 1'b1);
        tick(); tick();
        #2; check("t2_stall_count", stall_count, 32'd6);
        check("t2_issue_count", issue_count, 32'd4);

        // ACT waits on a busy MMU even with the activation unit idle
        drive(1'b1, 8'h20, 24'h00BBBB); mmu_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b0, 8'h00, 24'h0);
            resume = 1'b1;
            #2; check("t3_act_blocked", act_en, 1'b0);
        end
        tick(); mmu_busy = 1'b0; resume = 1'b0;
        #2; check("t3_act_en", act_en, 1'b1);
        tick();
        #2; check("t3_counts", {issue_count, stall_count}, {32'd5, 32'd9});

        // HALT drains behind a busy weight loader
        drive(1'b1, 8'hF8, 24'h0);
        tick(); drive(1'b0, 8'h00, 24'h0); weight_busy = 1'b1;
        #2; check("t4_halt_consumed", lab_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2; check("t4_drain", {lab_busy, halted, synchronize}, 3'b100);
        end
        tick(); weight_busy = 1'b0;
        tick();
        #2; check("t4_sync", {synchronize, halted, lab_busy}, 3'b111);
        tick(); resume = 1'b1;
        #2; check("t4_halted_hold", {synchronize, halted}, 2'b01);
        tick(); resume = 1'b0;
        #2; check("t4_resumed", {halted, lab_busy}, 2'b00);
        check("t4_stall_count", stall_count, 32'd13);

        // Async reset in the middle of DRAIN with an instruction held
        drive(1'b1, 8'hF8, 24'h0);
        tick(); drive(1'b1, 8'h08, 24'h0C0FFE); weight_busy = 1'b1;
        tick(); drive(1'b0, 8'h00, 24'h0);
        #2; check("t6_in_drain", lab_busy, 1'b1);
        rst = 1'b1; weight_busy = 1'b0;
        #1;
        check("t6_rst_busy", lab_busy, 1'b0);
        check("t6_rst_outs", {weight_en, mmu_en, act_en, synchronize, halted, illegal_opcode}, 6'b0);
        check("t6_rst_counts", {issue_count, stall_count}, 64'd0);
        check("t6_rst_instr", weight_instr, 32'h0);
        tick(); tick();
        rst = 1'b0;
        drive(1'b1, 8'h08, 24'h123456);
        tick(); drive(1'b0, 8'h00, 24'h0);
        #2; check("t6_weight_en", weight_en, 1'b1);
        check("t6_weight_instr", weight_instr, 32'h08123456);
        tick();
        #2; check("t6_issue_count", issue_count, 32'd1);
        tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
